// File: rtl/ram_memory_controller.sv
// Word-addressed RAM slave with configurable read/write latency behind an
// enable/functionComplete handshake; read+write cycles forward the write data.
module ram_memory_controller #(
    parameter int unsigned ADDRESS_WIDTH = 32,
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned DEPTH_LOG2    = 10,
    parameter int unsigned READ_LATENCY  = 4,
    parameter int unsigned WRITE_LATENCY = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [ADDRESS_WIDTH-1:0] address,
    input  logic                     readEnabled,
    input  logic                     writeEnabled,
    input  logic [DATA_WIDTH-1:0]    dataOut,
    output logic [DATA_WIDTH-1:0]    dataIn,
    output logic                     functionComplete,
    output logic                     busy
);
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned MAXL  = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
    localparam int unsigned CW    = (MAXL > 1) ? $clog2(MAXL) : 1;

    localparam logic [CW-1:0] READ_LOAD  = CW'(READ_LATENCY - 1);
    localparam logic [CW-1:0] WRITE_LOAD = CW'(WRITE_LATENCY - 1);
    localparam logic [CW-1:0] BOTH_LOAD  = CW'(MAXL - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    state_t                  r_state;
    logic [CW-1:0]           r_counter;
    logic [DEPTH_LOG2-1:0]   r_latchedAddress;
    logic [DATA_WIDTH-1:0]   r_latchedData;
    logic                    r_latchedRead;
    logic                    r_latchedWrite;
    logic [DATA_WIDTH-1:0]   r_mem [0:DEPTH-1];

    logic                    w_req;
    logic                    w_commit;
    logic [CW-1:0]           w_load;

    assign w_req            = readEnabled | writeEnabled;
    assign functionComplete = (r_state == DONE) && w_req;
    assign busy             = (r_state != IDLE);

    // Gated by reset so a write in flight is dropped rather than committed.
    assign w_commit = reset && (r_state == ACCESS) && w_req && (r_counter == '0);

    always_comb begin
        w_load = WRITE_LOAD;
        if (readEnabled && writeEnabled) begin
            w_load = BOTH_LOAD;
        end else if (readEnabled) begin
            w_load = READ_LOAD;
        end
    end

    generate
        if (ADDRESS_WIDTH > DEPTH_LOG2) begin : g_alias
            logic w_unused_addr;
            assign w_unused_addr = ^address[ADDRESS_WIDTH-1:DEPTH_LOG2];
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (w_commit && r_latchedWrite) begin
            r_mem[r_latchedAddress] <= r_latchedData;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state          <= IDLE;
            r_counter        <= '0;
            r_latchedAddress <= '0;
            r_latchedData    <= '0;
            r_latchedRead    <= 1'b0;
            r_latchedWrite   <= 1'b0;
            dataIn           <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_req) begin
                        r_latchedAddress <= address[DEPTH_LOG2-1:0];
                        r_latchedData    <= dataOut;
                        r_latchedRead    <= readEnabled;
                        r_latchedWrite   <= writeEnabled;
                        r_counter        <= w_load;
                        r_state          <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (!w_req) begin
                        r_state <= IDLE;
                    end else if (r_counter == '0) begin
                        // Read+write returns the latched write data so the reader never sees stale RAM.
                        if (r_latchedRead && r_latchedWrite) begin
                            dataIn <= r_latchedData;
                        end else if (r_latchedRead) begin
                            dataIn <= r_mem[r_latchedAddress];
                        end
                        r_state <= DONE;
                    end else begin
                        r_counter <= r_counter - 1'b1;
                    end
                end
                DONE: begin
                    if (!w_req) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ram_memory_controller.sv
// Self-checking bench for ram_memory_controller: vector table, hand-written
// corner sequences and randomized transactions against a word-array model.
module tb_ram_memory_controller;
    localparam int RL = 4;
    localparam int WL = 2;
    localparam int DL = 10;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] address = '0;
    logic        readEnabled = 1'b0;
    logic        writeEnabled = 1'b0;
    logic [31:0] dataOut = '0;
    logic [31:0] dataIn;
    logic        functionComplete;
    logic        busy;

    ram_memory_controller #(
        .ADDRESS_WIDTH(32),
        .DATA_WIDTH(32),
        .DEPTH_LOG2(DL),
        .READ_LATENCY(RL),
        .WRITE_LATENCY(WL)
    ) dut (
        .clock(clock),
        .reset(reset),
        .address(address),
        .readEnabled(readEnabled),
        .writeEnabled(writeEnabled),
        .dataOut(dataOut),
        .dataIn(dataIn),
        .functionComplete(functionComplete),
        .busy(busy)
    );

    always #5 clock = ~clock;

    int          n_total = 0;
    int          n_pass  = 0;
    logic [31:0] model_mem [0:(1<<DL)-1];
    bit          model_valid [0:(1<<DL)-1];

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        int          exp_lat;
        logic [31:0] exp_q;
        bit          chk_q;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    function automatic int exp_latency(input logic rd, input logic wr);
        if (rd && wr) return ((RL > WL) ? RL : WL) + 1;
        if (rd) return RL + 1;
        return WL + 1;
    endfunction

    // Starts just after a rising edge with the DUT idle; returns edges to completion (-1 on timeout).
    task automatic txn(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                       output int lat, output logic [31:0] q);
        int idx;
        readEnabled = rd; writeEnabled = wr; address = a; dataOut = d;
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clock); #1;
            if (i == 1) begin
                chk("busy_after_accept", {31'b0, busy}, 32'd1);
                address = 32'h3;
                dataOut = $urandom;
            end
            if (functionComplete) begin
                lat = i;
                break;
            end
        end
        q = dataIn;
        readEnabled = 1'b0; writeEnabled = 1'b0;
        @(posedge clock); #1;
        idx = int'(a % (1 << DL));
        if (wr && lat > 0) begin
            model_mem[idx] = d;
            model_valid[idx] = 1'b1;
        end
    endtask

    initial begin
        int          lat;
        logic [31:0] q;
        logic [31:0] prev;
        logic [31:0] a, d;
        int          op, idx;
        bit          seen_fc;

        for (int i = 0; i < (1 << DL); i++) model_valid[i] = 1'b0;

        vecs[0] = '{1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 3, 32'h0, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,         5, 32'hDEAD_BEEF, 1'b1};
        vecs[2] = '{1'b1, 1'b1, 32'h0000_0020, 32'h1234_5678, 5, 32'h1234_5678, 1'b1};
        vecs[3] = '{1'b1, 1'b0, 32'h0000_0020, 32'h0,         5, 32'h1234_5678, 1'b1};
        vecs[4] = '{1'b0, 1'b1, 32'h0000_0400, 32'h0000_0055, 3, 32'h0, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 32'h0000_0000, 32'h0,         5, 32'h0000_0055, 1'b1};
        vecs[6] = '{1'b0, 1'b1, 32'h0000_03FF, 32'hCAFE_F00D, 3, 32'h0, 1'b0};
        vecs[7] = '{1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0,         5, 32'hCAFE_F00D, 1'b1};

        repeat (3) @(posedge clock);
        #1;
        reset = 1'b1;
        chk("reset_busy", {31'b0, busy}, 32'd0);
        chk("reset_fc", {31'b0, functionComplete}, 32'd0);
        chk("reset_dataIn", dataIn, 32'h0);

        for (int i = 0; i < 8; i++) begin
            txn(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].data, lat, q);
            chk($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
            if (vecs[i].chk_q) chk($sformatf("vec%0d_data", i), q, vecs[i].exp_q);
        end

        // Reset during a write: the write must not land.
        txn(1'b0, 1'b1, 32'h5, 32'h11, lat, q);
        readEnabled = 1'b0; writeEnabled = 1'b1; address = 32'h5; dataOut = 32'hAA;
        @(posedge clock); #1;
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clock); #1;
            chk("rst_mid_busy", {31'b0, busy}, 32'd0);
            chk("rst_mid_fc", {31'b0, functionComplete}, 32'd0);
        end
        writeEnabled = 1'b0;
        reset = 1'b1;
        @(posedge clock); #1;
        txn(1'b1, 1'b0, 32'h5, 32'h0, lat, q);
        chk("rst_mid_read_back", q, 32'h11);

        // Master abort during ACCESS.
        txn(1'b1, 1'b0, 32'h20, 32'h0, lat, q);
        prev = dataIn;
        seen_fc = 1'b0;
        readEnabled = 1'b1; address = 32'h10;
        for (int i = 0; i < 2; i++) begin
            @(posedge clock); #1;
            if (functionComplete) seen_fc = 1'b1;
        end
        readEnabled = 1'b0;
        #1;
        if (functionComplete) seen_fc = 1'b1;
        @(posedge clock); #1;
        if (functionComplete) seen_fc = 1'b1;
        chk("abort_no_fc", {31'b0, seen_fc}, 32'd0);
        chk("abort_idle", {31'b0, busy}, 32'd0);
        chk("abort_dataIn_held", dataIn, prev);
        chk("abort_dataIn_value", dataIn, 32'h1234_5678);

        // Enables held past completion.
        readEnabled = 1'b1; address = 32'h10;
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clock); #1;
            if (functionComplete) begin lat = i; break; end
        end
        chk("hold_latency", lat, 32'(RL + 1));
        for (int i = 0; i < 3; i++) begin
            @(posedge clock); #1;
            chk("hold_fc_high", {31'b0, functionComplete}, 32'd1);
        end
        readEnabled = 1'b0;
        #1;
        chk("hold_fc_drop", {31'b0, functionComplete}, 32'd0);
        chk("hold_busy_still", {31'b0, busy}, 32'd1);
        @(posedge clock); #1;
        chk("hold_busy_fall", {31'b0, busy}, 32'd0);
        chk("hold_data", dataIn, 32'hDEAD_BEEF);

        // Randomized transactions against the word-array model.
        for (int n = 0; n < 60; n++) begin
            op = int'($urandom_range(0, 2));
            a = ($urandom & 32'hFFFF_FC00) | 32'($urandom_range(0, 15));
            d = $urandom;
            idx = int'(a % (1 << DL));
            prev = model_mem[idx];
            if (op == 0) begin
                txn(1'b1, 1'b0, a, d, lat, q);
                chk("rnd_rd_latency", lat, exp_latency(1'b1, 1'b0));
                if (model_valid[idx]) chk("rnd_rd_data", q, prev);
            end else if (op == 1) begin
                txn(1'b0, 1'b1, a, d, lat, q);
                chk("rnd_wr_latency", lat, exp_latency(1'b0, 1'b1));
            end else begin
                txn(1'b1, 1'b1, a, d, lat, q);
                chk("rnd_rw_latency", lat, exp_latency(1'b1, 1'b1));
                chk("rnd_rw_data", q, d);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_total);
        $fatal(1);
    end
endmodule
